// File: rtl/cnn_conv1_acc_relu.sv
// Accumulates TAPS signed products plus a channel bias, then applies ReLU, a shift and clip to an activation.
// Latency: out_vld rises 1 cycle after the last-tap accept; minimum period is TAPS+1 cycles per output.
// Backpressure: prod_rdy drops while an output is pending; the output holds stable until out_rdy=1.
//
// Ports:
//   ap_clk, ap_rst              single rising-edge clock, synchronous active-high reset
//   prod_dat/prod_vld/prod_rdy  signed product stream, one product per tap
//   bias                        signed channel bias, sampled only on the first-tap accept
//   out_dat/out_vld/out_rdy     unsigned activation result with valid/ready handshake
//   out_sat                     result was clipped to the maximum (qualified by out_vld)
module cnn_conv1_acc_relu #(
   parameter int TAPS   = 9,
   parameter int PROD_W = 24,
   parameter int BIAS_W = 16,
   parameter int ACC_W  = 28,
   parameter int SHIFT  = 8,
   parameter int OUT_W  = 14
) (
   input  logic                     ap_clk,
   input  logic                     ap_rst,
   input  logic signed [PROD_W-1:0] prod_dat,
   input  logic                     prod_vld,
   output logic                     prod_rdy,
   input  logic signed [BIAS_W-1:0] bias,
   output logic        [OUT_W-1:0]  out_dat,
   output logic                     out_vld,
   input  logic                     out_rdy,
   output logic                     out_sat
);

   localparam int CNT_W = $clog2(TAPS + 1);
   localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((1 << OUT_W) - 1);

   typedef enum logic {ST_ACC, ST_OUT} state_t;

   state_t                   state;
   logic [CNT_W-1:0]         tap_cnt;
   logic signed [ACC_W-1:0]  acc;
   logic signed [ACC_W-1:0]  sum;
   logic signed [ACC_W-1:0]  shr;
   logic signed [ACC_W-1:0]  prod_ext;
   logic signed [ACC_W-1:0]  bias_ext;
   logic                     accept;
   logic                     last;

   assign prod_rdy = (state == ST_ACC);
   assign accept   = prod_vld && prod_rdy;
   assign last     = (tap_cnt == CNT_W'(TAPS - 1));
   assign prod_ext = {{(ACC_W - PROD_W){prod_dat[PROD_W-1]}}, prod_dat};
   assign bias_ext = {{(ACC_W - BIAS_W){bias[BIAS_W-1]}}, bias};

   // Running sum including the product presented this cycle; the first tap
   // starts from the bias instead of the previous window's accumulator.
   always_comb begin
      sum = '0;
      if (tap_cnt == '0) begin
         sum = bias_ext + prod_ext;
      end else begin
         sum = acc + prod_ext;
      end
   end

   assign shr = sum >>> SHIFT;

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state   <= ST_ACC;
         tap_cnt <= '0;
         acc     <= '0;
         out_vld <= 1'b0;
         out_dat <= '0;
         out_sat <= 1'b0;
      end else begin
         case (state)
            ST_ACC: begin
               if (accept) begin
                  acc <= sum;
                  if (last) begin
                     tap_cnt <= '0;
                     state   <= ST_OUT;
                     out_vld <= 1'b1;
                     // ReLU on the full-precision sum, then shift and clip.
                     if (sum[ACC_W-1]) begin
                        out_dat <= '0;
                        out_sat <= 1'b0;
                     end else if (shr > MAXV) begin
                        out_dat <= {OUT_W{1'b1}};
                        out_sat <= 1'b1;
                     end else begin
                        out_dat <= shr[OUT_W-1:0];
                        out_sat <= 1'b0;
                     end
                  end else begin
                     tap_cnt <= tap_cnt + CNT_W'(1);
                  end
               end
            end
            ST_OUT: begin
               if (out_rdy) begin
                  out_vld <= 1'b0;
                  state   <= ST_ACC;
               end
            end
            default: state <= ST_ACC;
         endcase
      end
   end

endmodule

// File: tb/tb_cnn_conv1_acc_relu.sv
module tb_cnn_conv1_acc_relu;

   localparam int TAPS   = 9;
   localparam int PROD_W = 24;
   localparam int BIAS_W = 16;
   localparam int ACC_W  = 28;
   localparam int SHIFT  = 8;
   localparam int OUT_W  = 14;
   localparam int OMAX   = (1 << OUT_W) - 1;

   logic                     ap_clk = 1'b0;
   logic                     ap_rst;
   logic signed [PROD_W-1:0] prod_dat;
   logic                     prod_vld;
   logic                     prod_rdy;
   logic signed [BIAS_W-1:0] bias;
   logic        [OUT_W-1:0]  out_dat;
   logic                     out_vld;
   logic                     out_rdy;
   logic                     out_sat;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 ap_clk = ~ap_clk;

   cnn_conv1_acc_relu #(
      .TAPS(TAPS), .PROD_W(PROD_W), .BIAS_W(BIAS_W),
      .ACC_W(ACC_W), .SHIFT(SHIFT), .OUT_W(OUT_W)
   ) dut (
      .ap_clk   (ap_clk),
      .ap_rst   (ap_rst),
      .prod_dat (prod_dat),
      .prod_vld (prod_vld),
      .prod_rdy (prod_rdy),
      .bias     (bias),
      .out_dat  (out_dat),
      .out_vld  (out_vld),
      .out_rdy  (out_rdy),
      .out_sat  (out_sat)
   );

   typedef struct {
      int b;
      int p;
      int gap;
      int dat;
      int sat;
   } vec_t;

   vec_t tbl [12];

   task automatic check(input string name, input longint act, input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Reference: plain integer arithmetic on the whole window.
   function automatic void model(input int b, input int p [TAPS], output int d, output int s);
      longint total;
      longint r;
      total = b;
      for (int i = 0; i < TAPS; i++) total += p[i];
      if (total < 0) begin
         d = 0; s = 0;
      end else begin
         r = total / (64'sd1 <<< SHIFT);
         if (r > OMAX) begin d = OMAX; s = 1; end
         else begin d = int'(r); s = 0; end
      end
   endfunction

   task automatic tick();
      @(posedge ap_clk);
      #1;
   endtask

   task automatic send_tap(input int p, input int b);
      int t;
      logic [31:0] pv;
      logic [31:0] bv;
      t  = 0;
      pv = p;
      bv = b;
      prod_dat = pv[PROD_W-1:0];
      bias     = bv[BIAS_W-1:0];
      prod_vld = 1'b1;
      while (!prod_rdy && t < 50) begin
         tick();
         t++;
      end
      if (!prod_rdy) check("rdy_timeout", prod_rdy, 1);
      tick();
      prod_vld = 1'b0;
      bv = $urandom;
      pv = $urandom;
      bias     = bv[BIAS_W-1:0];
      prod_dat = pv[PROD_W-1:0];
   endtask

   // One full window: bias only valid on tap 0, garbage bias afterwards,
   // optional idle gaps, then a stalled output with prod_vld held high.
   task automatic run_window(input int b, input int p [TAPS], input int gap, input int stall,
                             output int got_dat, output int got_sat);
      logic [31:0] junk;
      for (int i = 0; i < TAPS; i++) begin
         send_tap(p[i], (i == 0) ? b : int'($urandom));
         if (i < TAPS - 1) begin
            if (out_vld) check("early_vld", out_vld, 0);
            for (int g = 0; g < gap; g++) tick();
         end
      end
      check("latency_vld", out_vld, 1);
      check("rdy_low_in_out", prod_rdy, 0);
      got_dat = out_dat;
      got_sat = out_sat;
      junk     = $urandom;
      prod_dat = junk[PROD_W-1:0];
      prod_vld = 1'b1;
      out_rdy  = 1'b0;
      for (int s = 0; s < stall; s++) begin
         tick();
         check("stall_dat", out_dat, got_dat);
         check("stall_sat", out_sat, got_sat);
         check("stall_vld", out_vld, 1);
         check("stall_rdy", prod_rdy, 0);
      end
      out_rdy = 1'b1;
      tick();
      out_rdy  = 1'b0;
      prod_vld = 1'b0;
      check("xfer_vld", out_vld, 0);
      check("xfer_rdy", prod_rdy, 1);
   endtask

   initial begin
      int parr [TAPS];
      int gd, gs, ed, es;
      ap_rst   = 1'b1;
      prod_vld = 1'b0;
      prod_dat = '0;
      bias     = '0;
      out_rdy  = 1'b0;
      tick();
      tick();
      check("rst_vld", out_vld, 0);
      check("rst_dat", out_dat, 0);
      check("rst_sat", out_sat, 0);
      check("rst_rdy", prod_rdy, 1);
      ap_rst = 1'b0;

      //          bias    prod     gap dat    sat
      tbl[0]  = '{0,      256,     0,  9,     0};
      tbl[1]  = '{0,      -1000,   0,  0,     0};
      tbl[2]  = '{0,      8388607, 0,  OMAX,  1};
      tbl[3]  = '{0,      1,       1,  0,     0};
      tbl[4]  = '{255,    1,       0,  1,     0};
      tbl[5]  = '{-32768, 8388607, 2,  OMAX,  1};
      tbl[6]  = '{3,      466005,  0,  OMAX,  0};
      tbl[7]  = '{259,    466005,  1,  OMAX,  1};
      tbl[8]  = '{-10,    1,       0,  0,     0};
      tbl[9]  = '{-9,     1,       0,  0,     0};
      tbl[10] = '{246,    1,       0,  0,     0};
      tbl[11] = '{0,      -8388608,0,  0,     0};

      for (int v = 0; v < 12; v++) begin
         for (int i = 0; i < TAPS; i++) parr[i] = tbl[v].p;
         run_window(tbl[v].b, parr, tbl[v].gap, v % 3, gd, gs);
         check($sformatf("tbl%0d_dat", v), gd, tbl[v].dat);
         check($sformatf("tbl%0d_sat", v), gs, tbl[v].sat);
      end

      // Long stall on the output.
      for (int i = 0; i < TAPS; i++) parr[i] = 256;
      run_window(0, parr, 0, 5, gd, gs);
      check("stall5_dat", gd, 9);
      check("stall5_sat", gs, 0);

      // Reset mid-window discards the partial sum, even with an accept pending.
      for (int i = 0; i < 4; i++) send_tap(5000, 1000);
      prod_vld = 1'b1;
      ap_rst   = 1'b1;
      tick();
      ap_rst   = 1'b0;
      prod_vld = 1'b0;
      check("midrst_vld", out_vld, 0);
      check("midrst_rdy", prod_rdy, 1);
      for (int i = 0; i < TAPS; i++) parr[i] = 256;
      run_window(256, parr, 0, 0, gd, gs);
      check("midrst_dat", gd, 10);
      check("midrst_sat", gs, 0);

      // Reset while an output is pending drops it, overriding the transfer.
      for (int i = 0; i < TAPS; i++) send_tap(100000, 0);
      check("pend_vld", out_vld, 1);
      out_rdy = 1'b1;
      ap_rst  = 1'b1;
      tick();
      ap_rst  = 1'b0;
      out_rdy = 1'b0;
      check("pendrst_vld", out_vld, 0);
      check("pendrst_dat", out_dat, 0);
      check("pendrst_sat", out_sat, 0);
      check("pendrst_rdy", prod_rdy, 1);

      // Randomized windows against the reference model.
      for (int w = 0; w < 30; w++) begin
         int b;
         b = int'($urandom_range(0, 65535)) - 32768;
         for (int i = 0; i < TAPS; i++) begin
            if (w % 2 == 0) parr[i] = int'($urandom_range(0, 16777215)) - 8388608;
            else            parr[i] = int'($urandom_range(0, 600000)) - 150000;
         end
         model(b, parr, ed, es);
         run_window(b, parr, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), gd, gs);
         check($sformatf("rnd%0d_dat", w), gd, ed);
         check($sformatf("rnd%0d_sat", w), gs, es);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/cnn_conv1_acc_relu.md
CNN_CONV1_ACC_RELU -- requirements
Module: cnn_conv1_acc_relu

Interface
REQ-001 SHALL have parameter TAPS, default 9, products accumulated per output pixel (3x3 window).
REQ-002 SHALL have parameter PROD_W, default 24, signed product width from the upstream 14s x 9s multiplier.
REQ-003 SHALL have parameter BIAS_W, default 16, signed bias width, already in product scale.
REQ-004 SHALL have parameter ACC_W, default 28, signed accumulator width (PROD_W + 4).
REQ-005 SHALL have parameter SHIFT, default 8, arithmetic right shift applied to the final sum.
REQ-006 SHALL have parameter OUT_W, default 14, unsigned-magnitude output activation width.
REQ-007 SHALL have port ap_clk, input, 1, the single clock; all logic on its rising edge.
REQ-008 SHALL have port ap_rst, input, 1, reset that is synchronous and active-high.
REQ-009 SHALL have port prod_dat, input, PROD_W, signed product.
REQ-010 SHALL have port prod_vld, input, 1, prod_dat valid.
REQ-011 SHALL have port prod_rdy, output, 1, block accepts a product this cycle.
REQ-012 SHALL have port bias, input, BIAS_W, signed channel bias, sampled only on the first-tap accept.
REQ-013 SHALL have port out_dat, output, OUT_W, activation result.
REQ-014 SHALL have port out_vld, output, 1, out_dat valid.
REQ-015 SHALL have port out_rdy, input, 1, downstream accepts out_dat.
REQ-016 SHALL have port out_sat, output, 1, result was clipped to the maximum; qualified by out_vld.

Function
REQ-017 SHALL define a product accept as prod_vld=1 and prod_rdy=1 on one rising edge.
REQ-018 SHALL implement two states, ACC and OUT; prod_rdy=1 in ACC, 0 in OUT.
REQ-019 SHALL keep tap_cnt 0..TAPS-1, incremented per accept, wrapping to 0 after the accept at TAPS-1.
REQ-020 SHALL load acc = sext(bias) + sext(prod_dat) on an accept with tap_cnt=0.
REQ-021 SHALL update acc = acc + sext(prod_dat) on an accept with tap_cnt>0, with no overflow possible at ACC_W.
REQ-022 SHALL hold acc and tap_cnt unchanged on cycles with no accept; idle gaps between taps are legal.
REQ-023 SHALL, on the accept at tap_cnt=TAPS-1, enter OUT and assert out_vld on the next cycle (1-cycle latency from last accept).
REQ-024 SHALL compute the output from the final sum S: if S<0, out_dat=0 and out_sat=0 (ReLU).
REQ-025 SHALL otherwise set R = S >>> SHIFT (truncation); if R > 2^OUT_W-1 then out_dat=2^OUT_W-1 (16383) and out_sat=1, else out_dat=R and out_sat=0.
REQ-026 SHALL hold out_dat, out_sat and out_vld stable in OUT while out_rdy=0.
REQ-027 SHALL, in OUT with out_rdy=1, complete the transfer, return to ACC and deassert out_vld on the next cycle.
REQ-028 SHALL NOT accept a product in the same cycle as an output transfer; the minimum period is TAPS+1 cycles per output.
REQ-029 SHALL ignore prod_dat and bias when no accept occurs.

Reset
REQ-030 SHALL, with ap_rst=1 at a rising edge, set state=ACC, tap_cnt=0, acc=0, out_vld=0, out_dat=0, out_sat=0; prod_rdy=1 from the next cycle.
REQ-031 SHALL let ap_rst override any simultaneous accept or output transfer, discarding the partial sum and any pending output.

Verification
REQ-032 SHALL pass: bias=0, 9 back-to-back products of 256 -> out_vld 1 cycle after the 9th accept, out_dat=9, out_sat=0.
REQ-033 SHALL pass: bias=0, 9 products of -1000 -> out_dat=0, out_sat=0.
REQ-034 SHALL pass: bias=0, 9 products of 8388607 -> out_dat=16383, out_sat=1.
REQ-035 SHALL pass: out_rdy held 0 for 5 cycles after out_vld -> out_dat/out_sat stable, prod_rdy=0 throughout; out_rdy=1 -> out_vld=0 and prod_rdy=1 next cycle.
REQ-036 SHALL pass: 4 taps accepted, then ap_rst pulsed 1 cycle, then bias=256 and 9 products of 256 -> out_dat=10, out_sat=0.
REQ-037 SHALL pass: products 1 each with prod_vld toggling every other cycle, bias=0 -> out_dat=0 (truncation), out_vld exactly 1 cycle after the 9th accept.
